// File: rtl/full_adder_pkg.sv
// ============================================================================
// full_adder_pkg : shared constants and reference helpers for full_adder_unit
// Revision 1.0
// ============================================================================
`default_nettype none

package full_adder_pkg;

  localparam int FA_DEFAULT_WIDTH = 9;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a ^ b));
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder_unit_fa_cell.sv
// ============================================================================
// fa_cell : combinational 1-bit full adder built from XOR/AND/OR gates
// Revision 1.0
// ============================================================================
`default_nettype none

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic axb;
  logic ab;
  logic cab;

  xor g_xor0 (axb, a, b);
  xor g_xor1 (s, axb, cin);
  and g_and0 (ab, a, b);
  and g_and1 (cab, cin, axb);
  or  g_or0  (cout, ab, cab);

endmodule

`default_nettype wire

// File: rtl/full_adder_unit.sv
// ============================================================================
// full_adder_unit : WIDTH independent full-adder lanes with registered outputs.
// Optional carry popcount output enabled by defining FA_CARRY_COUNT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module full_adder_unit
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] cout
`ifdef FA_CARRY_COUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] carry_cnt
`endif
);

  logic [WIDTH-1:0] lane_s;
  logic [WIDTH-1:0] lane_cout;

  // Lanes are isolated: each cell sees only its own cin bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    fa_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (cin[i]),
      .s    (lane_s[i]),
      .cout (lane_cout[i])
    );
  end

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] s_d, s_q;
  logic [WIDTH-1:0] cout_d, cout_q;

  // Idle cycles keep the last result, so X on idle inputs never reaches s/cout.
  always_comb begin
    out_valid_d = in_valid;
    s_d         = s_q;
    cout_d      = cout_q;
    if (in_valid) begin
      s_d    = lane_s;
      cout_d = lane_cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;

`ifdef FA_CARRY_COUNT_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] carry_cnt_d, carry_cnt_q;

  always_comb begin
    carry_cnt_d = carry_cnt_q;
    if (in_valid) begin
      carry_cnt_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
        carry_cnt_d = carry_cnt_d + CNT_W'(lane_cout[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt_q <= '0;
    end else begin
      carry_cnt_q <= carry_cnt_d;
    end
  end

  assign carry_cnt = carry_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_full_adder_unit.sv
// ============================================================================
// tb_full_adder_unit : scoreboard bench for full_adder_unit (WIDTH = 9)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_full_adder_unit;

  localparam int W  = 9;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  a, b, cin;
  logic          out_valid;
  logic [W-1:0]  s, cout;
`ifdef FA_CARRY_COUNT_EN
  logic [CW-1:0] carry_cnt;
`endif

  full_adder_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .s         (s),
    .cout      (cout)
`ifdef FA_CARRY_COUNT_EN
    ,
    .carry_cnt (carry_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          vld;
    logic [W-1:0]  s;
    logic [W-1:0]  c;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Model state: what s/cout/cnt should hold when idle.
  logic [W-1:0]  m_s   = '0;
  logic [W-1:0]  m_c   = '0;
  logic [CW-1:0] m_cnt = '0;

  // Per-lane truth table indexed by {a,b,cin}, value {cout,s}.
  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input logic vld, input logic [W-1:0] ia,
                               input logic [W-1:0] ib, input logic [W-1:0] ic);
    exp_t e;
    if (vld) begin
      m_cnt = '0;
      for (int i = 0; i < W; i++) begin
        logic [1:0] r;
        r       = tt[{ia[i], ib[i], ic[i]}];
        m_s[i]  = r[0];
        m_c[i]  = r[1];
        m_cnt   = m_cnt + CW'(r[1]);
      end
    end
    e.vld = vld;
    e.s   = m_s;
    e.c   = m_c;
    e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic compare_out(input string tag, output logic [W-1:0] s_obs,
                             output logic [W-1:0] c_obs);
    exp_t e;
    s_obs = s;
    c_obs = cout;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: observed=empty expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, "_valid"}, 32'(out_valid), 32'(e.vld));
    check({tag, "_s"},     32'(s),         32'(e.s));
    check({tag, "_cout"},  32'(cout),      32'(e.c));
`ifdef FA_CARRY_COUNT_EN
    check({tag, "_cnt"},   32'(carry_cnt), 32'(e.cnt));
`endif
  endtask

  task automatic step(input string tag, input logic vld, input logic [W-1:0] ia,
                      input logic [W-1:0] ib, input logic [W-1:0] ic,
                      output logic [W-1:0] s_obs, output logic [W-1:0] c_obs);
    @(negedge clk);
    in_valid = vld;
    a = ia;
    b = ib;
    cin = ic;
    push_expected(vld, ia, ib, ic);
    @(posedge clk);
    #1;
    compare_out(tag, s_obs, c_obs);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_s"},     32'(s),         32'd0);
    check({tag, "_cout"},  32'(cout),      32'd0);
  endtask

  // Two's-complement add/sub over W lanes, carries chained by the bench.
  task automatic ripple(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic sub, input logic [W-1:0] want);
    logic [W-1:0] yy, cc, so, co;
    yy = y ^ {W{sub}};
    cc = {{(W-1){1'b0}}, sub};
    for (int k = 0; k <= W; k++) begin
      step({tag, "_it"}, 1'b1, x, yy, cc, so, co);
      cc = {co[W-2:0], sub};
    end
    check({tag, "_result"}, 32'(so), 32'(want));
  endtask

  initial begin
    logic [W-1:0] so, co, s_hold, c_hold;

    // Reset with inputs toggling across clock edges.
    rst_n = 1'b0; in_valid = 1'b1; a = '1; b = '0; cin = '1;
    #2;
    check_reset_state("reset_async");
    repeat (2) begin
      @(negedge clk);
      a = ~a; b = ~b; cin = ~cin;
    end
    #1;
    check_reset_state("reset_held");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Exhaustive truth table in lane 0.
    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      v = 3'(k);
      step($sformatf("tt%0d", k), 1'b1, W'(v[2]), W'(v[1]), W'(v[0]), so, co);
    end

    step("all_ones_plus_one", 1'b1, 9'h1FF, 9'h001, 9'h000, so, co);
    check("case3_s", 32'(so), 32'h1FE);
    check("case3_c", 32'(co), 32'h001);
`ifdef FA_CARRY_COUNT_EN
    check("case3_cnt", 32'(carry_cnt), 32'd1);
`endif

    step("alt_bits", 1'b1, 9'h0AA, 9'h155, 9'h1FF, so, co);
    check("case4_s", 32'(so), 32'h000);
    check("case4_c", 32'(co), 32'h1FF);
`ifdef FA_CARRY_COUNT_EN
    check("case4_cnt", 32'(carry_cnt), 32'd9);
`endif

    // Hold: idle cycles with new and unknown data must not disturb outputs.
    s_hold = so;
    c_hold = co;
    step("hold_new", 1'b0, 9'h123, 9'h0F0, 9'h00F, so, co);
    step("hold_x",   1'b0, 'x, 'x, 'x, so, co);
    check("hold_s", 32'(so), 32'(s_hold));
    check("hold_c", 32'(co), 32'(c_hold));

    step("mixed", 1'b1, 9'h15A, 9'h0C3, 9'h1E1, so, co);

    // Reset asserted mid-stream, released before a normal edge.
    @(negedge clk);
    in_valid = 1'b1; a = 9'h1FF; b = 9'h1FF; cin = 9'h1FF;
    rst_n = 1'b0;
    #1;
    check_reset_state("reset_mid");
    m_s = '0; m_c = '0; m_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    push_expected(1'b1, a, b, cin);
    @(posedge clk);
    #1;
    compare_out("post_reset", so, co);

    ripple("sub_12_4", 9'd12,  9'd4, 1'b1, 9'd8);
    ripple("sub_0_1",  9'd0,   9'd1, 1'b1, 9'h1FF);
    ripple("add_511_1", 9'd511, 9'd1, 1'b0, 9'd0);

    @(negedge clk);
    in_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
